// File: rtl/riscv_pkg.sv
// Shared types for the RV32I front end: decode-facing fetch word, fetch FSM states.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Bit layout matches instruction_reg: {valid[64], pc[63:32], instr[31:0]}
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_word_t;

    typedef enum logic [1:0] {
        IF_RESET = 2'd0,
        IF_RUN   = 2'd1,
        IF_DRAIN = 2'd2,
        IF_HALT  = 2'd3
    } ifetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Flush wins over push/pop; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    assign full_c  = (cnt_q == CW'(DEPTH));
    assign empty_c = (cnt_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, in-order imem requests, prefetch FIFO, redirect with wrong-path drop.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect target sets fetch_misalign and halts fetch.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        cpu_clk_aon,
    input  logic        i_rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        update_pc,
    input  logic [31:0] new_pc,
    input  logic        cpu_stall_final,
    output logic [64:0] instruction_reg
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    ifetch_state_e state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          req_q, req_d;
    fetch_word_t   ir_q, ir_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   aq_mem_q [FIFO_DEPTH];
    logic [31:0]   aq_mem_d [FIFO_DEPTH];
    logic [AW-1:0] aq_wr_q, aq_wr_d;
    logic [AW-1:0] aq_rd_q, aq_rd_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic          misalign_q, misalign_d;
`endif

    logic          fire;
    logic          redirect;
    logic          bad_target;
    logic          accept;
    logic [31:0]   pc_tag;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [63:0]   fifo_wdata;
    logic [63:0]   fifo_rdata_c;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] fifo_cnt_nxt;
    logic          fifo_full_c;
    logic          fifo_empty_c;
    logic          unused_ok;

    assign pc_tag     = aq_mem_q[aq_rd_q];
    assign fifo_wdata = {pc_tag, imem_rdata};

    // Handshake bookkeeping, response routing and decode register update.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        drop_d     = drop_q;
        aq_mem_d   = aq_mem_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        bad_target = 1'b0;

        fire     = req_q & imem_gnt;
        redirect = update_pc & ~cpu_stall_final & (state_q != IF_HALT);
`ifdef IFETCH_MISALIGN_TRAP_EN
        bad_target = redirect & (new_pc[1:0] != 2'b00);
`endif
        accept = imem_rvalid & (drop_q == '0) & (state_q != IF_HALT);
        out_d  = out_q + CW'(fire) - CW'(imem_rvalid);

        if (redirect) begin
            fetch_pc_d = align_word(new_pc);
        end else if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            drop_d = out_d;
        end else if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        // Address tags track new-path grants only; a grant in the redirect cycle is dropped later.
        if (redirect) begin
            aq_wr_d = '0;
            aq_rd_d = '0;
        end else begin
            if (fire) begin
                aq_mem_d[aq_wr_q] = fetch_pc_q;
                aq_wr_d           = aq_wr_q + AW'(1);
            end
            if (accept) begin
                aq_rd_d = aq_rd_q + AW'(1);
            end
        end

        if (redirect) begin
            ir_d       = '0;
            fifo_flush = 1'b1;
        end else if (state_q == IF_HALT) begin
            ir_d = '0;
        end else if (!cpu_stall_final) begin
            if (!fifo_empty_c) begin
                ir_d      = '{valid: 1'b1, pc: fifo_rdata_c[63:32], instr: fifo_rdata_c[31:0]};
                fifo_pop  = 1'b1;
                fifo_push = accept;
            end else if (accept) begin
                ir_d = '{valid: 1'b1, pc: pc_tag, instr: imem_rdata};
            end else begin
                ir_d = '0;
            end
        end else begin
            fifo_push = accept;
        end

        fifo_cnt_nxt = fifo_flush ? '0 : (fifo_cnt + CW'(fifo_push) - CW'(fifo_pop));
    end

    // Next state; request is registered from next-cycle occupancy so it never follows update_pc combinationally.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if (bad_target) begin
                state_d = IF_HALT;
            end else if (out_d != '0) begin
                state_d = IF_DRAIN;
            end else begin
                state_d = IF_RUN;
            end
        end else begin
            case (state_q)
                IF_RESET: state_d = IF_RUN;
                IF_DRAIN: if (drop_d == '0) state_d = IF_RUN;
                default:  state_d = state_q;
            endcase
        end
        req_d = ((state_d == IF_RUN) || (state_d == IF_DRAIN)) &&
                ((SW'(fifo_cnt_nxt) + SW'(out_d)) < SW'(FIFO_DEPTH));
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misalign_d = misalign_q | bad_target;
`endif

    always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IF_RESET;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            ir_q       <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            aq_mem_q   <= '{default: '0};
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            ir_q       <= ir_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            aq_mem_q   <= aq_mem_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
        if (!i_rstn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`endif

    ifetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (cpu_clk_aon),
        .rst_n   (i_rstn),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (fifo_wdata),
        .rdata_c (fifo_rdata_c),
        .count   (fifo_cnt),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign imem_req        = req_q;
    assign imem_addr       = fetch_pc_q;
    assign instruction_reg = ir_q;

    // Low target bits are only inspected in the trap build; full is implied by the issue rule.
    assign unused_ok = &{1'b0, new_pc[1:0], fifo_full_c};

endmodule
